// File: rtl/dmac_pkg.sv
// dmac_pkg: shared constants for the single-channel DMA transfer sequencer.
// FSM encoding, config map, CTRL bit positions and word stride.
package dmac_pkg;

  localparam int DMAC_DATA_W = 32;
  localparam int DMAC_CNT_W  = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [1:0] CFG_SRC  = 2'd0;
  localparam logic [1:0] CFG_DST  = 2'd1;
  localparam logic [1:0] CFG_SIZE = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_CLR = 1;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmac_xfer_ctrl_if.sv
// dmac_bus_if: shared master bus between the DMA sequencer and the arbiter.
// master = DMA side, slave = arbiter/memory side.
interface dmac_bus_if #(
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_grant;
  logic              m_wr;
  logic [DATA_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );
endinterface

// File: rtl/dmac_cfg_regs.sv
// dmac_cfg_regs: SRC/DST/SIZE config words.
// Writes land only when the caller's enable says the channel is idle.
module dmac_cfg_regs
  import dmac_pkg::*;
#(
  parameter int DATA_W = DMAC_DATA_W,
  parameter int CNT_W  = DMAC_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] src_o,
  output logic [DATA_W-1:0] dst_o,
  output logic [CNT_W-1:0]  size_o
);

  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  size_q, size_d;

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    size_d = size_q;
    unique case (1'b1)
      wr_en && (addr == CFG_SRC):  src_d  = wdata;
      wr_en && (addr == CFG_DST):  dst_d  = wdata;
      wr_en && (addr == CFG_SIZE): size_d = wdata[CNT_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      size_q <= '0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      size_q <= size_d;
    end
  end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign size_o = size_q;

endmodule

// File: rtl/dmac_xfer_ctrl.sv
// dmac_xfer_ctrl: single-channel DMA sequencer, read-then-write word copy
// over the shared master bus, with a sticky completion interrupt.
module dmac_xfer_ctrl
  import dmac_pkg::*;
#(
  parameter int DATA_W = DMAC_DATA_W,
  parameter int CNT_W  = DMAC_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  dmac_bus_if.master        bus,
  output logic              busy,
  output logic              done_irq
);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] src_cnt_q, src_cnt_d;
  logic [DATA_W-1:0] dst_cnt_q, dst_cnt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              irq_q, irq_d;

  logic [DATA_W-1:0] cfg_src, cfg_dst;
  logic [CNT_W-1:0]  cfg_size;
  logic              is_idle, ctrl_wr, start, irq_clr;

  assign is_idle = (state_q == ST_IDLE);
  assign ctrl_wr = cfg_we && (cfg_addr == CFG_CTRL);
  assign start   = ctrl_wr && cfg_wdata[CTRL_START] && is_idle;
  assign irq_clr = ctrl_wr && cfg_wdata[CTRL_IRQ_CLR];

  dmac_cfg_regs #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_cfg (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cfg_we && is_idle),
    .addr    (cfg_addr),
    .wdata   (cfg_wdata),
    .src_o   (cfg_src),
    .dst_o   (cfg_dst),
    .size_o  (cfg_size)
  );

  always_comb begin
    state_d   = state_q;
    src_cnt_d = src_cnt_q;
    dst_cnt_d = dst_cnt_q;
    rem_d     = rem_q;
    data_d    = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_cnt_d = cfg_src;
          dst_cnt_d = cfg_dst;
          rem_d     = cfg_size;
          state_d   = (cfg_size == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.m_grant) state_d = ST_RD;
      end
      ST_RD: begin
        state_d = bus.m_grant ? ST_CAP : ST_REQ;
      end
      ST_CAP: begin
        data_d  = bus.m_din;
        state_d = ST_WR;
      end
      // grant is not sampled here: a captured word is always written back
      ST_WR: begin
        src_cnt_d = src_cnt_q + DATA_W'(WORD_BYTES);
        dst_cnt_d = dst_cnt_q + DATA_W'(WORD_BYTES);
        rem_d     = rem_q - CNT_W'(1);
        state_d   = (rem_q == CNT_W'(1)) ? ST_DONE : ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // a set from DONE overrides a clear landing in the same cycle
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (state_q == ST_DONE) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_cnt_q <= '0;
      dst_cnt_q <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_cnt_q <= src_cnt_d;
      dst_cnt_q <= dst_cnt_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    bus.m_req  = 1'b0;
    bus.m_wr   = 1'b0;
    bus.m_addr = '0;
    bus.m_dout = '0;
    case (state_q)
      ST_REQ: bus.m_req = 1'b1;
      ST_RD: begin
        bus.m_req  = 1'b1;
        bus.m_addr = src_cnt_q;
      end
      ST_CAP: bus.m_req = 1'b1;
      ST_WR: begin
        bus.m_req  = 1'b1;
        bus.m_wr   = 1'b1;
        bus.m_addr = dst_cnt_q;
        bus.m_dout = data_q;
      end
      default: ;
    endcase
  end

  assign busy     = !is_idle;
  assign done_irq = irq_q;

endmodule

// File: tb/tb_dmac_xfer_ctrl.sv
// tb_dmac_xfer_ctrl: table vectors, corner sequences and randomized copies
// checked against a word-list model of the transfer.
module tb_dmac_xfer_ctrl;
  import dmac_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        grant;
    logic        req;
    logic        wr;
    logic        busy;
    logic        irq;
    logic [31:0] maddr;
    logic [31:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        busy;
  logic        done_irq;

  dmac_bus_if #(.DATA_W(32)) bus ();

  dmac_xfer_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .bus       (bus),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit rand_grant = 1'b0;
  int done_rise = 0;
  int req_seen = 0;
  logic irq_prev = 1'b0;
  logic [63:0] wq[$];
  vec_t tbl[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // memory answers one cycle after the address it saw
  always @(posedge clk) bus.m_din <= mem_f(bus.m_addr);

  always @(negedge clk) begin
    if (rand_grant) bus.m_grant = ($urandom_range(0, 3) != 0);
    if (reset_n && bus.m_req && bus.m_wr) wq.push_back({bus.m_addr, bus.m_dout});
    if (bus.m_req) req_seen++;
    if (done_irq && !irq_prev) done_rise++;
    irq_prev = done_irq;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] a, input logic [31:0] d,
                              input logic g, input logic req, input logic w,
                              input logic b, input logic irq,
                              input logic [31:0] ma, input logic [31:0] dout);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.grant = g;
    v.req = req; v.wr = w; v.busy = b; v.irq = irq; v.maddr = ma; v.dout = dout;
    return v;
  endfunction

  task automatic run_xfer(input string nm, input logic [31:0] src, input logic [31:0] dst,
                          input int size, input bit rnd);
    bit hit;
    logic [63:0] exp_w;
    wr(CFG_CTRL, 32'h2);
    wr(CFG_SRC, src);
    wr(CFG_DST, dst);
    wr(CFG_SIZE, 32'(size));
    wq.delete();
    done_rise = 0;
    rand_grant = rnd;
    wr(CFG_CTRL, 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_irq) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    rand_grant = 1'b0;
    bus.m_grant = 1'b1;
    chk({nm, "_done"}, {127'd0, hit}, 128'd1);
    idle(2);
    chk({nm, "_len"}, 128'(wq.size()), 128'(size));
    chk({nm, "_irqs"}, 128'(done_rise), 128'd1);
    for (int i = 0; i < size && i < wq.size(); i++) begin
      exp_w = {dst + 32'(4 * i), mem_f(src + 32'(4 * i))};
      chk($sformatf("%s_w%0d", nm, i), 128'(wq[i]), 128'(exp_w));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    bus.m_grant = 1'b0;
    bus.m_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bus.m_req, bus.m_wr, busy, done_irq, bus.m_addr, bus.m_dout}, '0);
    reset_n = 1'b1;
    idle(1);

    // basic copy, grant held
    tbl.push_back(mk(1, CFG_SRC, 32'h100, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, CFG_DST, 32'h200, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, CFG_SIZE, 32'h3, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, CFG_CTRL, 32'h1, 1, 1, 0, 1, 0, 0, 0));
    for (int w = 0; w < 3; w++) begin
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 32'h100 + 32'(4 * w), 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 32'h200 + 32'(4 * w),
                       mem_f(32'h100 + 32'(4 * w))));
    end
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, CFG_CTRL, 32'h2, 1, 0, 0, 0, 0, 0, 0));
    // grant lost in CAP of the first word
    tbl.push_back(mk(1, CFG_SRC, 32'h300, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, CFG_DST, 32'h400, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, CFG_SIZE, 32'h2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, CFG_CTRL, 32'h1, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 32'h300, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 32'h400, mem_f(32'h300)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 32'h304, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 32'h304, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 32'h404, mem_f(32'h304)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, CFG_CTRL, 32'h2, 1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cfg_we = tbl[i].we;
      cfg_addr = tbl[i].addr;
      cfg_wdata = tbl[i].wdata;
      bus.m_grant = tbl[i].grant;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      chk($sformatf("row%0d", i),
          {bus.m_req, bus.m_wr, busy, done_irq, bus.m_addr, bus.m_dout},
          {tbl[i].req, tbl[i].wr, tbl[i].busy, tbl[i].irq, tbl[i].maddr, tbl[i].dout});
    end

    // zero size and the clear/set race in DONE
    wr(CFG_SIZE, 32'h0);
    req_seen = 0;
    wr(CFG_CTRL, 32'h1);
    chk("zero_in_done", {busy, done_irq}, 2'b10);
    wr(CFG_CTRL, 32'h2);
    chk("race_set_wins", {busy, done_irq}, 2'b01);
    idle(1);
    chk("zero_no_req", 128'(req_seen), 128'd0);
    wr(CFG_CTRL, 32'h2);
    chk("late_clear", {busy, done_irq}, 2'b00);

    // clear and start together from IDLE
    wr(CFG_CTRL, 32'h1);
    idle(1);
    chk("irq_pre", {busy, done_irq}, 2'b01);
    wr(CFG_CTRL, 32'h3);
    chk("clr_start_a", {busy, done_irq}, 2'b10);
    idle(1);
    chk("clr_start_b", {busy, done_irq}, 2'b01);

    run_xfer("wrap", 32'hFFFF_FFFC, 32'h10, 2, 1'b0);

    // busy lockout
    wr(CFG_CTRL, 32'h2);
    wr(CFG_SRC, 32'h500);
    wr(CFG_DST, 32'h600);
    wr(CFG_SIZE, 32'h3);
    wq.delete();
    done_rise = 0;
    bus.m_grant = 1'b1;
    wr(CFG_CTRL, 32'h1);
    idle(1);
    wr(CFG_DST, 32'hDEAD);
    wr(CFG_CTRL, 32'h1);
    idle(30);
    chk("lock_irqs", 128'(done_rise), 128'd1);
    chk("lock_len", 128'(wq.size()), 128'd3);
    chk("lock_idle", {127'd0, busy}, 128'd0);
    if (wq.size() == 3)
      chk("lock_dst", {wq[0][63:32], wq[2][63:32]}, {32'h600, 32'h608});

    // reset in WR
    wr(CFG_SIZE, 32'h4);
    wr(CFG_CTRL, 32'h1);
    for (int i = 0; i < 50; i++) begin
      if (bus.m_wr) break;
      idle(1);
    end
    chk("rst_in_wr", {127'd0, bus.m_wr}, 128'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_outs", {bus.m_req, bus.m_wr, busy, done_irq, bus.m_addr, bus.m_dout}, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_xfer("post_rst", 32'h40, 32'h80, 1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_xfer($sformatf("rnd%0d", k), $urandom & 32'hFFFF_FFFC,
               $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 6)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
